// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, stage record and constants for pipelined_divider
package divider_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    localparam logic [DW_DEF-1:0] QUO_DZ = '1;

    typedef struct packed {
        logic [VW_DEF:0]   rem;
        logic [DW_DEF-1:0] dividend;
        logic [DW_DEF-1:0] quotient;
        logic [VW_DEF-1:0] divisor;
        logic              valid;
        logic              dz;
    } stage_t;

endpackage

// File: rtl/div_stage.sv
// rtl/div_stage.sv - one combinational restoring-division step on a stage record
module div_stage
    import divider_pkg::*;
(
    input  stage_t in_rec,
    output stage_t out_rec
);

    logic [VW_DEF:0] t;
    logic [VW_DEF:0] d;
    logic            qbit;

    always_comb begin
        t    = {in_rec.rem[VW_DEF-1:0], in_rec.dividend[DW_DEF-1]};
        d    = {1'b0, in_rec.divisor};
        // A set top bit of the partial remainder means t overflowed and is certainly >= d.
        qbit = in_rec.rem[VW_DEF] | (t >= d);

        out_rec          = in_rec;
        out_rec.rem      = qbit ? (t - d) : t;
        out_rec.dividend = in_rec.dividend << 1;
        out_rec.quotient = (in_rec.quotient << 1) | {{(DW_DEF-1){1'b0}}, qbit};
    end

endmodule

// File: rtl/pipelined_divider.sv
// rtl/pipelined_divider.sv - fully pipelined unsigned restoring divider, one op per clock
module pipelined_divider
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] x,
    input  logic [VW-1:0] y,
    output logic          out_valid,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz
);

    // pipe[0] is the capture stage, pipe[DW] the retire register that holds across bubbles.
    stage_t pipe [DW+1];
    stage_t nxt  [DW];

    for (genvar k = 0; k < DW; k++) begin : g_stage
        div_stage u_stage (
            .in_rec  (pipe[k]),
            .out_rec (nxt[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DW; k++) begin
                pipe[k].valid <= 1'b0;
            end
            pipe[DW] <= '0;
        end else begin
            pipe[0].rem      <= '0;
            pipe[0].dividend <= x;
            pipe[0].quotient <= '0;
            pipe[0].divisor  <= y;
            pipe[0].valid    <= in_valid;
            pipe[0].dz       <= (y == '0);
            for (int k = 1; k < DW; k++) begin
                pipe[k] <= nxt[k-1];
            end
            if (nxt[DW-1].valid) begin
                pipe[DW] <= nxt[DW-1];
            end else begin
                pipe[DW].valid <= 1'b0;
            end
        end
    end

    assign out_valid = pipe[DW].valid;
    assign dz        = pipe[DW].dz;
    assign q         = pipe[DW].dz ? QUO_DZ : pipe[DW].quotient;
    assign r         = pipe[DW].dz ? '0 : pipe[DW].rem[VW-1:0];

endmodule

// File: doc/pipelined_divider.md
# pipelined_divider

Fully pipelined unsigned restoring divider that inverts the datapath of `pipelined_multiplier`. It accepts an 8-bit dividend and a 4-bit divisor every clock and returns an 8-bit quotient and a 4-bit remainder a fixed number of cycles later. It sits alongside the multiplier, so a product `z = x*y` fed back with divisor `y` recovers `x` with remainder 0. One operation may enter per cycle; there is no backpressure.

## Interface
Parameters:
- `DW`, 8, dividend and quotient width; also the number of compute stages.
- `VW`, 4, divisor and remainder width.

Ports:
- `clk`  input  1  rising-edge clock; the single clock domain.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  when high, `x`/`y` hold an operation that is sampled at this edge.
- `x`  input  DW  unsigned dividend.
- `y`  input  VW  unsigned divisor.
- `out_valid`  output  1  `q`/`r`/`dz` hold a retired result this cycle.
- `q`  output  DW  quotient, floor(x/y).
- `r`  output  VW  remainder, x mod y.
- `dz`  output  1  divide-by-zero flag for the current result.

## Operation
- Stage 0 registers `x`, `y` and `in_valid` with no arithmetic.
- Stages 1..DW each resolve one quotient bit, MSB first.
- Each stage carries these fields:
  - partial remainder, VW+1 bits;
  - remaining dividend bits;
  - quotient bits built so far;
  - divisor;
  - valid bit;
  - zero-divisor bit.
- Step at stage k:
  - t = {rem[VW-1:0], next dividend bit};
  - if t >= {1'b0, y}: rem = t - y and qbit = 1;
  - else: rem = t and qbit = 0.
- Width rules:
  - The compare and subtract are VW+1 bits wide.
  - The final remainder is always < y, so it fits VW bits.
  - The quotient is the full DW bits, since 255/1 = 255.
- Divide by zero (y == 0):
  - The flag is detected at stage 0 and travels with the operation.
  - At retire, the outputs are forced to q = all ones (8'hFF), r = 0, dz = 1.
  - For valid operations with nonzero y, dz = 0.
- Bubbles:
  - With `in_valid` low, an invalid slot travels through the pipe.
  - When that slot retires, `out_valid` = 0 and `q`/`r`/`dz` hold their last retired values.
- Operations retire in issue order with no reordering and no dropping, except on reset.
- There is no state machine. Control is purely the per-stage valid bits.

## Timing
- Latency: an operation sampled at edge n appears on `q`/`r`/`dz` with `out_valid` = 1 after edge n+DW, i.e. 8 cycles later at default widths.
- Throughput: 1 operation per cycle. Back-to-back operations appear on consecutive cycles.
- Reset (`rst_n` low at an edge):
  - All valid bits clear.
  - `out_valid` = 0, `q` = 0, `r` = 0, `dz` = 0 after that edge.
  - Data fields of the stages need not be reset.
- Reset mid-stream: every in-flight operation is discarded. The first operation sampled on or after the first edge with `rst_n` high retires DW edges later. No stale result ever appears with `out_valid` = 1.
- `in_valid` high during reset is ignored.

## Structure
- Package `divider_pkg` holds:
  - the `DW` and `VW` defaults;
  - the stage-record struct typedef (rem, dividend, quotient, divisor, valid, dz);
  - the constant `QUO_DZ` = all ones.
- One sub-module, `div_stage`:
  - combinational one-bit restore step on a stage record (record in, record out);
  - instantiated DW times by a generate loop in `pipelined_divider`, which owns all the registers.

## Test plan
- Single operations x=40,y=5; x=28,y=7; x=27,y=3 -> q=8,r=0; q=4,r=0; q=9,r=0; each arrives exactly 8 cycles after issue with `out_valid` = 1 for one cycle.
- Boundaries:
  - x=255,y=1 -> q=255,r=0.
  - x=200,y=15 -> q=13,r=5.
  - x=3,y=9 -> q=0,r=3.
  - x=0,y=4 -> q=0,r=0.
- Divide by zero: x=100,y=0 -> q=8'hFF,r=0,dz=1. The next operation x=6,y=4 -> q=1,r=2,dz=0.
- Streaming and round trip:
  - Issue 10 back-to-back operations with z=x*y, for pairs including (3,2), (8,5), (6,8), (2,9), then divide z by y.
  - Required: 10 consecutive `out_valid` cycles, in order, each with q=x and r=0.
- Bubbles: alternate `in_valid` 1/0 -> `out_valid` alternates 1/0 with the same spacing, and `q`/`r` hold during the 0 cycles.
- Reset mid-stream: pull `rst_n` low for 1 cycle while 5 operations are in flight -> `out_valid` stays 0 for those operations, the outputs read 0, and an operation issued after reset retires correctly 8 cycles later.
